// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_DONE
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_loader_if.sv
// Byte stream from the UART receiver, instruction-memory write port and
// load status, bundled between the loader (master) and its surroundings.
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [7:0]            rx_byte;
  logic                  rx_byte_valid;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  load_active;
  logic                  load_done;
  logic                  load_error;

  modport master (
    input  rx_byte, rx_byte_valid,
    output imem_we, imem_addr, imem_wdata, load_active, load_done, load_error
  );

  modport slave (
    output rx_byte, rx_byte_valid,
    input  imem_we, imem_addr, imem_wdata, load_active, load_done, load_error
  );

endinterface

// File: rtl/uart_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by the count and data phases.
// word/word_ready are combinational so the caller can register the finished
// word on the same edge that accepts its last byte.
module uart_loader_byte_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam int LOW_W = 8 * (WORD_BYTES - 1);

  logic [IDX_W-1:0] byte_idx;
  logic [LOW_W-1:0] low_bytes;

  assign word_ready = byte_valid && !clear && (byte_idx == IDX_W'(WORD_BYTES - 1));
  assign word       = {byte_in, low_bytes};

  // Shift each byte in from the top so byte 0 ends up least significant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx  <= '0;
      low_bytes <= '0;
    end else if (clear) begin
      byte_idx  <= '0;
    end else if (byte_valid) begin
      low_bytes <= {byte_in, low_bytes[LOW_W-1:8]};
      byte_idx  <= byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Program loader: waits for the sync byte, reads a 32-bit word count and
// then writes that many little-endian words to consecutive imem addresses.
// A bad count or an inter-byte gap that reaches the timeout aborts the load
// with a sticky error, which is cleared by the next accepted sync byte.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_loader_if.master bus
);

  localparam int                IDX_W     = ADDR_WIDTH - 2;
  localparam logic [32:0]       MAX_WORDS = 33'd1 << IDX_W;
  localparam int                GAP_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CLKS - 1);

  loader_state_t         state_q, state_d;
  logic [31:0]           count_q, count_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic                  active_d;
  logic                  done_d;
  logic                  err_d;

  logic                  in_frame;
  logic                  timeout;
  logic                  count_bad;
  logic                  last_word;
  logic                  pk_clear;
  logic                  pk_valid;
  logic                  pk_ready;
  logic [31:0]           pk_word;

  // The packer only sees bytes while a frame is being parsed; it is held
  // cleared otherwise so every frame starts on byte 0.
  assign in_frame  = (state_q == S_COUNT) || (state_q == S_DATA);
  assign pk_clear  = !in_frame;
  assign pk_valid  = bus.rx_byte_valid && in_frame;
  // A byte arriving on the terminal gap cycle takes priority over the timeout.
  assign timeout   = in_frame && !bus.rx_byte_valid && (gap_q == GAP_LAST);
  // Range check on the full 32-bit count so large values cannot alias.
  assign count_bad = (pk_word == 32'd0) || ({1'b0, pk_word} > MAX_WORDS);
  assign last_word = (32'(idx_q) == (count_q - 32'd1));

  uart_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_in    (bus.rx_byte),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    gap_d   = '0;
    we_d    = 1'b0;
    addr_d  = bus.imem_addr;
    wdata_d = bus.imem_wdata;
    done_d  = 1'b0;
    err_d   = bus.load_error;

    if (in_frame && !bus.rx_byte_valid) begin
      gap_d = gap_q + GAP_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_byte_valid && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_COUNT: begin
        if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (pk_ready) begin
          count_d = pk_word;
          if (count_bad) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (pk_ready) begin
          we_d    = 1'b1;
          addr_d  = {idx_q, 2'b00};
          wdata_d = pk_word;
          idx_d   = idx_q + IDX_W'(1);
          if (last_word) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.load_done) begin
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE);
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      idx_q           <= '0;
      gap_q           <= '0;
      bus.imem_we     <= 1'b0;
      bus.imem_addr   <= '0;
      bus.imem_wdata  <= '0;
      bus.load_active <= 1'b0;
      bus.load_done   <= 1'b0;
      bus.load_error  <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      idx_q           <= idx_d;
      gap_q           <= gap_d;
      bus.imem_we     <= we_d;
      bus.imem_addr   <= addr_d;
      bus.imem_wdata  <= wdata_d;
      bus.load_active <= active_d;
      bus.load_done   <= done_d;
      bus.load_error  <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames from the test plan
// plus randomized frames compared against a byte-list parsing model.
module tb_uart_loader;

  localparam int AW   = 12;
  localparam int TO   = 40;
  localparam int MAXW = 1 << (AW - 2);

  typedef logic [7:0] bq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_loader #(
    .ADDR_WIDTH   (AW),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed writes and done pulses.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];
  logic          active_after_done;
  logic          done_prev = 1'b0;

  // Expected results from the model.
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic          exp_err;
  logic          exp_done;

  bq_t frame_q;

  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Sample DUT outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done_prev) active_after_done = bus.load_active;
    done_prev = bus.load_done;
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.load_done) done_cyc_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    bus.rx_byte       = b;
    bus.rx_byte_valid = 1'b1;
    tick();
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte       = 8'h00;
    repeat (idle) tick();
  endtask

  task automatic send_bytes(input bq_t q, input int max_idle);
    foreach (q[i]) send_byte(q[i], int'($urandom_range(max_idle, 0)));
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    active_after_done = 1'b1;
  endtask

  // Sync byte, little-endian count, then nwords random words.
  function automatic void build_frame(input logic [31:0] cnt, input int nwords);
    frame_q.delete();
    frame_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frame_q.push_back(cnt[8*i +: 8]);
    for (int i = 0; i < 4 * nwords; i++) frame_q.push_back(8'($urandom));
  endfunction

  // Reference model: scan a byte list for a frame and list the writes it implies.
  function automatic void model_parse(input bq_t b);
    int          i;
    logic [31:0] cnt;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    i = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i + 5 > b.size()) return;
    cnt = {b[i+4], b[i+3], b[i+2], b[i+1]};
    i += 5;
    if (cnt == 0 || cnt > 32'(MAXW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < int'(cnt); w++) begin
      if (i + 4 > b.size()) return;
      exp_addr_q.push_back(AW'(w * 4));
      exp_data_q.push_back({b[i+3], b[i+2], b[i+1], b[i]});
      i += 4;
    end
    exp_done = 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rx_byte_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.load_active, bus.load_done, bus.load_error} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs we=%b addr=%h wdata=%h active=%b done=%b err=%b expected all 0",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.load_active, bus.load_done, bus.load_error);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    int dlat;
    clear_obs();
    send_byte(8'hA5, 0);
    checks++;
    if (bus.load_active !== 1'b1) begin
      failures++; $display("[TB] FAIL basic_active_rise actual=%b expected=1", bus.load_active);
    end
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    send_bytes(frame_q, 3);
    repeat (6) tick();
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++; $display("[TB] FAIL basic_write_count actual=%0d expected=2", wr_addr_q.size());
    end
    if (wr_addr_q.size() == 2) begin
      checks++;
      if (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'hDEADBEEF) begin
        failures++; $display("[TB] FAIL basic_word0 actual=%h@%h expected=deadbeef@000", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 12'h004 || wr_data_q[1] !== 32'h12345678) begin
        failures++; $display("[TB] FAIL basic_word1 actual=%h@%h expected=12345678@004", wr_data_q[1], wr_addr_q[1]);
      end
    end
    dlat = (done_cyc_q.size() == 1 && wr_cyc_q.size() > 0) ? done_cyc_q[0] - wr_cyc_q[wr_cyc_q.size()-1] : -1;
    checks++;
    if (dlat != 1) begin
      failures++; $display("[TB] FAIL basic_done_latency actual=%0d expected=1", dlat);
    end
    checks++;
    if (active_after_done !== 1'b0 || bus.load_active !== 1'b0 || bus.load_error !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_end_state active_after_done=%b active=%b err=%b expected 0/0/0",
                           active_after_done, bus.load_active, bus.load_error);
    end
  endtask

  task automatic test_garbage_and_sync_in_data();
    clear_obs();
    frame_q = '{8'h00, 8'hFF, 8'h13};
    send_bytes(frame_q, 3);
    repeat (3) tick();
    checks++;
    if (wr_addr_q.size() != 0 || bus.load_active !== 1'b0) begin
      failures++; $display("[TB] FAIL garbage_ignored writes=%0d active=%b expected 0/0", wr_addr_q.size(), bus.load_active);
    end
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hA5, 8'h11};
    send_bytes(frame_q, 3);
    repeat (6) tick();
    checks++;
    if (wr_addr_q.size() != 1) begin
      failures++; $display("[TB] FAIL garbage_write_count actual=%0d expected=1", wr_addr_q.size());
    end
    if (wr_addr_q.size() == 1) begin
      checks++;
      if (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'h11A55AA5) begin
        failures++; $display("[TB] FAIL sync_as_data actual=%h@%h expected=11a55aa5@000", wr_data_q[0], wr_addr_q[0]);
      end
    end
  endtask

  task automatic test_bad_count();
    logic [31:0] bad[3];
    bad = '{32'h0000_0000, 32'h0000_0401, 32'h8000_0001};
    foreach (bad[k]) begin
      clear_obs();
      build_frame(bad[k], 0);
      send_bytes(frame_q, 2);
      repeat (4) tick();
      checks++;
      if (bus.load_error !== 1'b1 || wr_addr_q.size() != 0 || bus.load_active !== 1'b0) begin
        failures++; $display("[TB] FAIL bad_count_%h err=%b writes=%0d active=%b expected 1/0/0",
                             bad[k], bus.load_error, wr_addr_q.size(), bus.load_active);
      end
    end
  endtask

  task automatic test_random_loads();
    int n;
    int ng;
    logic [7:0] g;
    for (int t = 0; t < 6; t++) begin
      clear_obs();
      n  = int'($urandom_range(8, 1));
      ng = int'($urandom_range(3, 0));
      build_frame(32'(n), n);
      for (int j = 0; j < ng; j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h3C;
        frame_q.push_front(g);
      end
      model_parse(frame_q);
      send_bytes(frame_q, 8);
      repeat (6) tick();
      checks++;
      if (wr_addr_q.size() != exp_addr_q.size()) begin
        failures++; $display("[TB] FAIL rand%0d_write_count actual=%0d expected=%0d", t, wr_addr_q.size(), exp_addr_q.size());
      end
      for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
          failures++; $display("[TB] FAIL rand%0d_word%0d actual=%h@%h expected=%h@%h",
                               t, i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
        end
      end
      checks++;
      if ((done_cyc_q.size() == 1) !== exp_done || bus.load_error !== exp_err) begin
        failures++; $display("[TB] FAIL rand%0d_status dones=%0d err=%b expected done=%b err=%b",
                             t, done_cyc_q.size(), bus.load_error, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_max_count();
    int bad;
    clear_obs();
    build_frame(32'(MAXW), MAXW);
    model_parse(frame_q);
    send_bytes(frame_q, 0);
    repeat (6) tick();
    checks++;
    if (wr_addr_q.size() != MAXW) begin
      failures++; $display("[TB] FAIL max_write_count actual=%0d expected=%0d", wr_addr_q.size(), MAXW);
    end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++)
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("[TB] FAIL max_words_content mismatching=%0d expected=0", bad);
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== AW'(4 * (MAXW - 1)) ||
        done_cyc_q.size() != 1 || bus.load_error !== 1'b0) begin
      failures++; $display("[TB] FAIL max_last_addr writes=%0d dones=%0d err=%b expected last addr %h, one done, no error",
                           wr_addr_q.size(), done_cyc_q.size(), bus.load_error, AW'(4 * (MAXW - 1)));
    end
  endtask

  task automatic test_stall();
    clear_obs();
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
    send_bytes(frame_q, 2);
    send_byte(8'h22, 0);
    repeat (TO - 1) tick();
    checks++;
    if (bus.load_error !== 1'b0 || bus.load_active !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_before_terminal err=%b active=%b expected 0/1", bus.load_error, bus.load_active);
    end
    tick();
    checks++;
    if (bus.load_error !== 1'b1 || bus.load_active !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_at_terminal err=%b active=%b expected 1/0", bus.load_error, bus.load_active);
    end
    send_bytes('{8'h33, 8'h44}, 2);
    repeat (4) tick();
    checks++;
    if (wr_addr_q.size() != 0) begin
      failures++; $display("[TB] FAIL stall_no_write actual=%0d expected=0", wr_addr_q.size());
    end
    build_frame(32'd1, 1);
    model_parse(frame_q);
    send_bytes(frame_q, 4);
    repeat (6) tick();
    checks++;
    if (wr_addr_q.size() != 1 || bus.load_error !== 1'b0 ||
        (wr_addr_q.size() == 1 && (wr_addr_q[0] !== exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0]))) begin
      failures++; $display("[TB] FAIL stall_recovery writes=%0d err=%b expected 1 write of %h, err 0",
                           wr_addr_q.size(), bus.load_error, exp_data_q[0]);
    end
  endtask

  task automatic test_boundary_race();
    clear_obs();
    build_frame(32'd2, 2);
    model_parse(frame_q);
    foreach (frame_q[i]) send_byte(frame_q[i], TO - 1);
    repeat (4) tick();
    checks++;
    if (bus.load_error !== 1'b0 || done_cyc_q.size() != 1 || wr_addr_q.size() != 2) begin
      failures++; $display("[TB] FAIL race_status err=%b dones=%0d writes=%0d expected 0/1/2",
                           bus.load_error, done_cyc_q.size(), wr_addr_q.size());
    end
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
        failures++; $display("[TB] FAIL race_word%0d actual=%h@%h expected=%h@%h",
                             i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t head;
    clear_obs();
    build_frame(32'd3, 3);
    model_parse(frame_q);
    for (int i = 0; i < 11; i++) head.push_back(frame_q[i]);
    send_bytes(head, 2);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.load_active, bus.load_done, bus.load_error} !== '0) begin
      failures++; $display("[TB] FAIL midreset_outputs we=%b addr=%h wdata=%h active=%b done=%b err=%b expected all 0",
                           bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.load_active, bus.load_done, bus.load_error);
    end
    rst_n = 1'b1;
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 2);
    repeat (4) tick();
    checks++;
    if (wr_addr_q.size() != 1 || bus.load_active !== 1'b0 ||
        (wr_addr_q.size() == 1 && wr_data_q[0] !== exp_data_q[0])) begin
      failures++; $display("[TB] FAIL midreset_no_more_writes writes=%0d active=%b expected 1/0",
                           wr_addr_q.size(), bus.load_active);
    end
    clear_obs();
    build_frame(32'd1, 1);
    model_parse(frame_q);
    send_bytes(frame_q, 3);
    repeat (6) tick();
    checks++;
    if (wr_addr_q.size() != 1 || (wr_addr_q.size() == 1 && (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== exp_data_q[0]))) begin
      failures++; $display("[TB] FAIL midreset_fresh_load writes=%0d expected 1 write of %h at 000",
                           wr_addr_q.size(), exp_data_q[0]);
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    test_reset();
    test_basic_load();
    test_garbage_and_sync_in_data();
    test_bad_count();
    test_random_loads();
    test_max_count();
    test_stall();
    test_boundary_race();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Program loader sitting directly downstream of the UART receiver. It consumes the receiver's byte/valid pulse stream and parses a framed image: sync byte, 32-bit word count, then little-endian 32-bit words. Each completed word is written to instruction memory at consecutive word-aligned byte addresses. The block flags the load as active so the core is held off, and pulses done on completion; malformed or stalled transfers abort with a sticky error.

## Interface
- ADDR_WIDTH, 12: imem byte-address width; MAX_WORDS = 2**(ADDR_WIDTH-2) is derived.
- TIMEOUT_CLKS, 1_000_000: max idle clocks between bytes inside a frame (10 ms at 100 MHz).
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- rx_byte  in  8  received byte, valid only while rx_byte_valid=1.
- rx_byte_valid  in  1  single-cycle strobe per received byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  byte address; bits [1:0] always 0.
- imem_wdata  out  32  word to write.
- load_active  out  1  high while a frame is in progress; the core is held in reset on it.
- load_done  out  1  one-cycle pulse after the final word is written.
- load_error  out  1  sticky abort flag.

## Operation
- Frame: SYNC_BYTE (0xA5), count[7:0], count[15:8], count[23:16], count[31:24], then count words, each sent byte 0 first.
- States: S_IDLE, S_COUNT, S_DATA, S_DONE.
- **S_IDLE**
  - A valid byte equal to 0xA5 goes to S_COUNT, clears load_error, and clears the byte index and word index.
  - All other bytes are ignored.
- **S_COUNT**
  - Shifts 4 bytes into word_count.
  - On the 4th byte: count==0 or count>MAX_WORDS sets load_error and returns to S_IDLE.
  - Otherwise goes to S_DATA.
- **S_DATA**
  - Bytes are packed little-endian by byte index 0..3.
  - On the 4th byte: register imem_wdata, set imem_addr = word_idx<<2, pulse imem_we, increment word_idx, reset byte index.
  - If this was word count-1, go to S_DONE.
- **S_DONE**
  - Pulses load_done for one cycle, then goes to S_IDLE.
- **Timeout**
  - In S_COUNT and S_DATA, a gap counter is cleared on every rx_byte_valid and incremented otherwise.
  - At TIMEOUT_CLKS-1: set load_error, go to S_IDLE.
  - A partially assembled word is discarded and never written.
- load_active = 1 in S_COUNT, S_DATA and S_DONE; 0 in S_IDLE.
- Widths and arithmetic:
  - word_idx is ADDR_WIDTH-2 bits.
  - The count comparison uses the full 32-bit count, so no truncation before the range check.
  - The gap counter is sized by $clog2(TIMEOUT_CLKS).

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, load_active=0, load_done=0, load_error=0, state=S_IDLE.
- All outputs are registered.
- imem_we rises in the cycle after the rx_byte_valid of a word's 4th byte. imem_addr and imem_wdata are stable in that cycle.
- load_done is high in the cycle directly after the final imem_we. load_active falls in the cycle after load_done.
- load_active rises in the cycle after the accepted sync byte.
- No backpressure: input bytes are at least 10×868 clocks apart, and every write completes in 1 cycle.
- If rx_byte_valid arrives in the same cycle the gap counter reaches terminal count, the byte wins: it is processed and the counter clears.
- rst_n low mid-frame aborts with no further write. load_error returns to 0, not set.
- A 0xA5 byte inside S_COUNT or S_DATA is data, not resync.
- Last word at MAX_WORDS-1: imem_addr = 4·(MAX_WORDS-1). word_idx wrapping to 0 is harmless because the state exits.

## Structure
- Shared package uart_loader_pkg: loader_state_t enum, SYNC_BYTE constant, WORD_BYTES=4.
- One natural sub-module, byte_packer. It holds the little-endian byte-to-word shift and the 2-bit byte index, with a word_ready pulse. It is reused by S_COUNT and S_DATA.
- The top holds the FSM, word_idx, gap counter and output registers.

## Test plan
- **Basic load:** A5, 02 00 00 00, EF BE AD DE, 78 56 34 12 -> writes 0xDEADBEEF@0x000 and 0x12345678@0x004. load_done one cycle after the 2nd imem_we. load_active low afterwards.
- **Garbage before sync:** 00 FF 13, then a valid 1-word frame -> no activity before 0xA5; exactly one write.
- **Bad count:** A5 00 00 00 00 -> load_error=1, no imem_we. A5 with count 0x401 (ADDR_WIDTH=12) -> load_error=1, no imem_we.
- **Stall mid-word:** A5, count 1, then 2 data bytes, then silence for TIMEOUT_CLKS -> load_error=1, no write. A following valid frame clears load_error and loads.
- **Boundary race:** the next byte lands exactly on the terminal-count cycle -> no error, load completes.
- **Reset mid-frame:** rst_n low after 6 data bytes -> all outputs 0 the next cycle, no further imem_we, and a fresh frame loads from address 0.
